// File: rtl/t_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | t_ram                                                                      |
// | Single-port SRAM model behind an async-SRAM style bus (WE/OE, shared DATA) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module t_ram #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int INIT_ZERO = 1
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              WE,
  input  logic              OE,
  input  logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              we_act;
  logic              oe_act;
  logic              wr_en;
  logic              rd_cyc;
  logic              drive_en;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              drive_d;
  logic              drive_q;

  // Strobes count as active only when cleanly low; X/Z is treated as inactive.
  always_comb begin
    we_act   = (WE === 1'b0);
    oe_act   = (OE === 1'b0);
    wr_en    = we_act & RESET_N;
    rd_cyc   = oe_act & ~we_act;
    drive_en = drive_q & oe_act & ~we_act;
  end

  // Storage has no reset so contents survive RESET_N.
  generate
    if (INIT_ZERO != 0) begin : g_init_zero
      logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
      always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
          mem[ADDR] <= DATA;
        end
      end
      assign mem_rd = mem[ADDR];
    end else begin : g_init_x
      logic [DATA_W-1:0] mem [DEPTH];
      always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
          mem[ADDR] <= DATA;
        end
      end
      assign mem_rd = mem[ADDR];
    end
  endgenerate

  always_comb begin
    rdata_d = rdata_q;
    drive_d = 1'b0;
    if (rd_cyc) begin
      rdata_d = mem_rd;
      drive_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rdata_q <= '0;
      drive_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      drive_q <= drive_d;
    end
  end

  // Driver gated by the live strobes so the bus releases without a clock edge.
  assign DATA = drive_en ? rdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_t_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_t_ram                                                                   |
// | Directed plus random bus cycles against an associative-array memory model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_t_ram;

  localparam logic [15:0] FLOAT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic        oe;
  logic [15:0] addr;
  logic [15:0] m_data;
  logic        m_en;
  tri1  [15:0] data_bus;

  always #5 clk = ~clk;

  assign data_bus = m_en ? m_data : 16'hzzzz;

  t_ram #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .INIT_ZERO(1)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .WE      (we),
    .OE      (oe),
    .ADDR    (addr),
    .DATA    (data_bus)
  );

  logic [15:0] model [logic [15:0]];
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [15:0] mget(input logic [15:0] a);
    return model.exists(a) ? model[a] : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Tasks start and end just after a falling edge.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic oe_v);
    addr   = a;
    we     = 1'b0;
    oe     = oe_v;
    m_en   = 1'b1;
    m_data = d;
    @(posedge clk);
    @(negedge clk);
    chk("wr_bus", data_bus, d);
    model[a] = d;
    we   = 1'b1;
    oe   = 1'b1;
    m_en = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input string tag);
    addr = a;
    we   = 1'b1;
    oe   = 1'b0;
    m_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk(tag, data_bus, mget(a));
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] a;
    rst_n  = 1'b0;
    we     = 1'b1;
    oe     = 1'b0;
    addr   = 16'h0000;
    m_en   = 1'b0;
    m_data = 16'h0000;

    // Reset held with a read pending: bus must float.
    repeat (3) begin
      @(negedge clk);
      chk("rst_z", data_bus, FLOAT);
    end
    // Write attempt under reset must be ignored.
    we = 1'b0; m_en = 1'b1; m_data = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    we = 1'b1; m_en = 1'b0;
    rst_n = 1'b1;
    do_read(16'h0000, "rst_rd0");

    do_write(16'h0005, 16'h1234, 1'b1);
    do_read(16'h0005, "wr_rd5");

    // Read-modify-write loop on address 0.
    for (int i = 0; i < 4; i++) begin
      do_read(16'h0000, "rmw_rd");
      chk("rmw_val", data_bus, 16'(i));
      v = data_bus;
      do_write(16'h0000, v + 16'h0001, 1'b1);
    end
    do_read(16'h0000, "rmw_final");
    chk("rmw_four", data_bus, 16'h0004);

    // Write with OE low: no contention, word stored.
    do_write(16'h0009, 16'hBEEF, 1'b0);
    do_read(16'h0009, "beef_rd");

    // Combinational release on OE rise / WE fall.
    do_read(16'h0005, "gate_rd");
    oe = 1'b1;
    #1 chk("oe_gate", data_bus, FLOAT);
    oe = 1'b0;
    #1 chk("oe_regain", data_bus, 16'h1234);
    we = 1'b0;
    #1 chk("we_gate", data_bus, FLOAT);
    we = 1'b1;
    @(negedge clk);

    // Reset asserted mid-read.
    do_read(16'h0005, "mid_rd");
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_z", data_bus, FLOAT);
    @(negedge clk);
    chk("mid_rst_hold", data_bus, FLOAT);
    rst_n = 1'b1;
    do_read(16'h0005, "mid_after");

    // Address extremes.
    do_write(16'hFFFF, 16'hAAAA, 1'b1);
    do_write(16'h0000, 16'h5555, 1'b1);
    do_read(16'hFFFF, "wrap_hi");
    chk("wrap_hi_val", data_bus, 16'hAAAA);
    do_read(16'h0000, "wrap_lo");
    chk("wrap_lo_val", data_bus, 16'h5555);

    // Random mix of writes and back-to-back reads.
    repeat (120) begin
      case ($urandom_range(0, 3))
        0:       a = 16'hFFFF;
        1:       a = 16'h0000;
        2:       a = 16'($urandom_range(0, 7));
        default: a = 16'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, 16'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        do_read(a, "rand_rd");
      end
    end

    // Idle cycle releases the bus.
    we = 1'b1;
    oe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_z", data_bus, FLOAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/t_ram.md
# t_ram

Synchronous single-port 16-bit SRAM model with an SRAM-style asynchronous-bus interface: active-low write enable, active-low output enable, and a shared bidirectional data bus. It stands in for the board SRAM in simulation and in small on-chip test builds. The controller and testbenches drive its address, strobes and data bus directly. Contents are retained across reset; only the bus interface state is reset.

## Interface
- ADDR_W, 16: address width; depth = 2**ADDR_W words.
- DATA_W, 16: word width.
- INIT_ZERO, 1: when 1, every word holds 0 at time zero; when 0, contents are undefined (X) at time zero.

Ports:
- CLOCK_50  in  1  sole clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- WE  in  1  write enable, active low.
- OE  in  1  output enable, active low.
- ADDR  in  ADDR_W  word address; bit 0 is the LSB.
- DATA  inout  DATA_W  shared data bus; written by the master during writes, driven by t_ram during reads, high-Z otherwise.

## Operation
- Internal state:
  - mem[2**ADDR_W] of DATA_W bits.
  - rdata register, DATA_W bits.
  - drive flag, 1 bit.
- Write cycle (WE=0, any OE):
  - At the rising edge, mem[ADDR] <= DATA (value sampled on the bus).
  - t_ram never drives DATA while WE=0; write has priority over read.
- Read cycle (WE=1, OE=0):
  - At the rising edge, rdata <= mem[ADDR] and drive <= 1.
  - DATA = rdata while drive=1 and OE=0 and WE=1.
- Idle (WE=1, OE=1): no memory change; drive <= 0 at the edge; DATA = Z.
- Output driver is gated combinationally: DATA goes to Z immediately when OE rises or WE falls, without waiting for a clock.
- Read-during-write to the same address cannot happen, since a write suppresses the read path. Back-to-back write then read of the same address returns the newly written word.
- Reset (RESET_N=0):
  - Asynchronously clears rdata to 0 and drive to 0; DATA goes to Z immediately.
  - mem is untouched.
  - Write and read strobes are ignored while reset is held.
- X/Z on WE or OE is treated as inactive (no write, no drive).
- Address wrap: ADDR is used modulo the depth; no out-of-range case exists.

## Timing
- Write latency: data is stored at the edge where WE=0; readable from the next edge.
- Read latency: 1 clock.
  - ADDR presented with OE=0 and WE=1 before edge N gives valid DATA after edge N.
  - After edge N, DATA follows ADDR changes one edge later.
- Continuous read (OE held low, WE high): new word every clock for the ADDR sampled at each edge.
- Reset deassertion: the first active edge is the first rising edge with RESET_N=1. The first read then returns after that edge.
- Reset outputs: DATA = Z, rdata = 0, drive = 0.

## Test plan
- Reset drive state:
  - Stimulus: RESET_N=0 with OE=0, WE=1.
  - Required: DATA=Z throughout; release reset, ADDR=0 read gives 0x0000 after one edge (INIT_ZERO=1).
- Write then read:
  - Stimulus: write 0x1234 to ADDR 0x0005 (WE=0, master drives bus), then WE=1, OE=0, ADDR 0x0005.
  - Required: DATA=0x1234 one edge later.
- Read-modify-write loop:
  - Stimulus: read ADDR 0, increment, write back, repeat 4 times.
  - Required: reads return 0,1,2,3; final mem[0]=4.
- Bus release on write:
  - Stimulus: OE=0 and WE=0 with the master driving 0xBEEF.
  - Required: t_ram never drives DATA (no contention); mem[ADDR]=0xBEEF.
- Reset mid-read:
  - Stimulus: assert RESET_N=0 while DATA is driving 0x1234.
  - Required: DATA=Z immediately; after release, mem[0x0005] still reads 0x1234.
- Address wrap:
  - Stimulus: write 0xAAAA to 0xFFFF and 0x5555 to 0x0000.
  - Required: reads of 0xFFFF and 0x0000 return 0xAAAA and 0x5555 respectively.
